// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST sequencer: FSM states, algorithm
// select codes and the default per-algorithm run timeout.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SETTLE,
        RUN,
        CAPTURE,
        FINISH
    } state_t;

    localparam int ALGO_BLANKET = 0;
    localparam int ALGO_CHECKER = 1;
    localparam int ALGO_MARCH   = 2;
    localparam int ALGO_MARCHLR = 3;
    localparam int FUNC_SEL     = 4;

    // Long enough for a 256x4b March pass.
    localparam int TIMEOUT_CYCLES_DEF = 8192;

endpackage

// File: rtl/bist_seq_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Shared between the settle window and the run timeout.
module bist_seq_timer #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && count != '0)
            count <= count - 1'b1;
    end

    assign expired = (count == '0);

endmodule

// File: rtl/bist_sequencer.sv
// Runs the enabled BIST engines in select order, latching pass/fail per engine,
// then parks sel on the functional code. Optional BIST_SEQ_RETRY_EN re-runs a failing engine once.
module bist_sequencer
#(
    parameter int NUM_ALGOS      = 4,
    parameter int FUNC_SEL       = bist_pkg::FUNC_SEL,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = bist_pkg::TIMEOUT_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_ALGOS-1:0] algo_mask,
    input  logic [NUM_ALGOS-1:0] done_in,
    input  logic                 gonogo_in,
    output logic [2:0]           sel,
    output logic                 busy,
    output logic                 seq_done,
    output logic [NUM_ALGOS-1:0] pass_vec,
    output logic [NUM_ALGOS-1:0] ran_vec,
    output logic                 all_pass,
    output logic                 timeout_err
`ifdef BIST_SEQ_RETRY_EN
    ,
    output logic [NUM_ALGOS-1:0] retry_vec
`endif
);

    import bist_pkg::*;

    // idx needs one extra code so stepping past the last engine is visible in SCAN.
    localparam int IDX_W = $clog2(NUM_ALGOS + 1);
    localparam int AW    = $clog2(NUM_ALGOS);
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 4) ? $clog2(TIMEOUT_CYCLES) : 4;
    localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_VAL    = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               state, next_state;
    logic [IDX_W-1:0]     idx;
    logic [AW-1:0]        idx_lo;
    logic [NUM_ALGOS-1:0] mask_q;
    logic                 found;
    logic [AW-1:0]        found_idx;
    logic                 tmr_load, tmr_en, tmr_expired;
    logic [CNT_W-1:0]     tmr_val;

    assign idx_lo   = idx[AW-1:0];
    assign busy     = (state != IDLE);
    assign seq_done = (state == FINISH);

    bist_seq_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int k = 0; k < NUM_ALGOS; k++) begin
            if (!found && mask_q[k] && IDX_W'(k) >= idx) begin
                found     = 1'b1;
                found_idx = AW'(k);
            end
        end
    end

    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_en     = 1'b0;
        case (state)
            IDLE: if (start) next_state = SCAN;
            SCAN: begin
                if (found) begin
                    next_state = SETTLE;
                    tmr_load   = 1'b1;
                    tmr_val    = SETTLE_VAL;
                end else begin
                    next_state = FINISH;
                end
            end
            SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    next_state = RUN;
                    tmr_load   = 1'b1;
                    tmr_val    = RUN_VAL;
                end
            end
            RUN: begin
                // done wins over expiry on the last allowed cycle
                tmr_en = 1'b1;
                if (done_in[idx_lo])
                    next_state = CAPTURE;
                else if (tmr_expired)
                    next_state = SCAN;
            end
            CAPTURE: begin
                next_state = SCAN;
`ifdef BIST_SEQ_RETRY_EN
                if (!gonogo_in && !retry_vec[idx_lo]) begin
                    next_state = SETTLE;
                    tmr_load   = 1'b1;
                    tmr_val    = SETTLE_VAL;
                end
`endif
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            mask_q      <= '0;
            sel         <= 3'(FUNC_SEL);
            pass_vec    <= '0;
            ran_vec     <= '0;
            all_pass    <= 1'b0;
            timeout_err <= 1'b0;
`ifdef BIST_SEQ_RETRY_EN
            retry_vec   <= '0;
`endif
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q      <= algo_mask;
                        idx         <= '0;
                        pass_vec    <= '0;
                        ran_vec     <= '0;
                        all_pass    <= 1'b0;
                        timeout_err <= 1'b0;
`ifdef BIST_SEQ_RETRY_EN
                        retry_vec   <= '0;
`endif
                    end
                end
                SCAN: begin
                    if (found) begin
                        idx                <= IDX_W'(found_idx);
                        sel                <= 3'(found_idx);
                        ran_vec[found_idx] <= 1'b1;
                    end else begin
                        sel      <= 3'(FUNC_SEL);
                        all_pass <= &(pass_vec | ~ran_vec);
                    end
                end
                RUN: begin
                    if (!done_in[idx_lo] && tmr_expired) begin
                        timeout_err      <= 1'b1;
                        pass_vec[idx_lo] <= 1'b0;
                        idx              <= idx + IDX_W'(1);
                    end
                end
                CAPTURE: begin
                    pass_vec[idx_lo] <= gonogo_in;
`ifdef BIST_SEQ_RETRY_EN
                    if (!gonogo_in && !retry_vec[idx_lo])
                        retry_vec[idx_lo] <= 1'b1;
                    else
                        idx <= idx + IDX_W'(1);
`else
                    idx <= idx + IDX_W'(1);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_sequencer.sv
// Randomized bench for bist_sequencer: behavioural engines drive done/gonogo,
// and a per-algorithm cost model predicts results and sequence latency.
module tb_bist_sequencer;
    import bist_pkg::*;

    localparam int NA = 4;
    localparam int S  = 2;
    localparam int T  = 64;

    logic          clk = 1'b0;
    logic          rst_n, start, gonogo_in;
    logic [NA-1:0] algo_mask, done_in, pass_vec, ran_vec;
    logic [2:0]    sel;
    logic          busy, seq_done, all_pass, timeout_err;
`ifdef BIST_SEQ_RETRY_EN
    logic [NA-1:0] retry_vec;
`endif

    int total = 0;
    int bad   = 0;

    int            delay [NA];
    logic          res1  [NA];
    logic          res2  [NA];
    int            cnt   [NA];
    logic [NA-1:0] noise;

    int            exp_cycles;
    logic [NA-1:0] exp_ran, exp_pass, exp_retry;
    logic          exp_to, exp_all;

    bist_sequencer #(
        .NUM_ALGOS      (NA),
        .FUNC_SEL       (FUNC_SEL),
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .algo_mask   (algo_mask),
        .done_in     (done_in),
        .gonogo_in   (gonogo_in),
        .sel         (sel),
        .busy        (busy),
        .seq_done    (seq_done),
        .pass_vec    (pass_vec),
        .ran_vec     (ran_vec),
        .all_pass    (all_pass),
        .timeout_err (timeout_err)
`ifdef BIST_SEQ_RETRY_EN
        ,
        .retry_vec   (retry_vec)
`endif
    );

    always #5 clk = ~clk;

    // Engine k counts cycles while selected; done is a level once delay is reached.
    always @(posedge clk)
        for (int k = 0; k < NA; k++)
            cnt[k] <= (sel == 3'(k)) ? cnt[k] + 1 : 0;

    // Unselected done bits carry random noise; result flips after the first report.
    always_comb begin
        done_in   = noise;
        gonogo_in = 1'b1;
        for (int k = 0; k < NA; k++) begin
            if (sel == 3'(k)) begin
                done_in[k] = (cnt[k] >= delay[k]);
                gonogo_in  = (cnt[k] <= ((delay[k] > S) ? delay[k] : S) + 1) ? res1[k] : res2[k];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        noise = NA'($urandom);
    endtask

    task automatic set_all(input int d, input logic r1, input logic r2);
        for (int k = 0; k < NA; k++) begin
            delay[k] = d;
            res1[k]  = r1;
            res2[k]  = r2;
        end
    endtask

    // Cost per engine: SCAN + settle + run + CAPTURE, or SCAN + settle + T on timeout;
    // plus the final SCAN and FINISH.
    task automatic ref_model(input logic [NA-1:0] mask);
        int r;
        exp_cycles = 2;
        exp_ran    = '0;
        exp_pass   = '0;
        exp_retry  = '0;
        exp_to     = 1'b0;
        for (int k = 0; k < NA; k++) begin
            if (mask[k]) begin
                exp_ran[k] = 1'b1;
                r = ((delay[k] > S) ? delay[k] : S) - S + 1;
                if (r > T) begin
                    exp_cycles += 1 + S + T;
                    exp_to = 1'b1;
                end else begin
                    exp_cycles += 2 + S + r;
                    if (res1[k]) begin
                        exp_pass[k] = 1'b1;
                    end else begin
`ifdef BIST_SEQ_RETRY_EN
                        exp_retry[k] = 1'b1;
                        exp_cycles  += S + 2;
                        exp_pass[k]  = res2[k];
`endif
                    end
                end
            end
        end
        exp_all = &(exp_pass | ~exp_ran);
    endtask

    task automatic run_seq(input logic [NA-1:0] mask, input bit restart);
        int            n;
        logic [NA-1:0] seen;
        logic          order_bad;
        logic [2:0]    last;
        ref_model(mask);
        seen      = '0;
        order_bad = 1'b0;
        last      = 3'd0;
        algo_mask = mask;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        algo_mask = NA'($urandom);
        n         = 1;
        chk("busy_after_start", busy, 1);
        while (!seq_done && n < exp_cycles + 20) begin
            if (sel < 3'(NA)) begin
                if (sel < last) order_bad = 1'b1;
                last = sel;
                seen[sel[1:0]] = 1'b1;
            end
            start = restart && (n == 3);
            tick();
            n++;
        end
        start = 1'b0;
        chk("latency", n, exp_cycles);
        chk("seq_done", seq_done, 1);
        chk("ran_vec", ran_vec, exp_ran);
        chk("pass_vec", pass_vec, exp_pass);
        chk("all_pass", all_pass, exp_all);
        chk("timeout_err", timeout_err, exp_to);
        chk("sel_parked", sel, FUNC_SEL);
        chk("sel_visited", seen, exp_ran);
        chk("sel_order", order_bad, 0);
`ifdef BIST_SEQ_RETRY_EN
        chk("retry_vec", retry_vec, exp_retry);
`endif
        tick();
        chk("done_pulse", seq_done, 0);
        chk("idle_busy", busy, 0);
        chk("pass_hold", pass_vec, exp_pass);
    endtask

    initial begin
        int w;
        rst_n     = 1'b0;
        start     = 1'b0;
        algo_mask = '0;
        noise     = '0;
        set_all(5, 1'b1, 1'b1);
        repeat (3) tick();
        chk("rst_sel", sel, FUNC_SEL);
        chk("rst_busy", busy, 0);
        chk("rst_seq_done", seq_done, 0);
        chk("rst_pass", pass_vec, 0);
        chk("rst_ran", ran_vec, 0);
        chk("rst_all_pass", all_pass, 0);
        chk("rst_timeout", timeout_err, 0);
        rst_n = 1'b1;
        tick();

        // all engines pass, with a second start while busy
        set_all(10, 1'b1, 1'b1);
        run_seq(4'b1111, 1'b1);

        // engine 2 fails, 1 and 3 skipped
        set_all(10, 1'b1, 1'b1);
        res1[ALGO_MARCH] = 1'b0;
        res2[ALGO_MARCH] = 1'b0;
        run_seq(4'b0101, 1'b0);

        // engine 1 never finishes
        set_all(10, 1'b1, 1'b1);
        delay[ALGO_CHECKER] = 100000;
        run_seq(4'b0010, 1'b0);

        // done exactly on the last run cycle vs one cycle late
        set_all(S + T - 1, 1'b1, 1'b1);
        delay[ALGO_MARCHLR] = S + T;
        run_seq(4'b1001, 1'b0);

        // empty mask
        run_seq(4'b0000, 1'b0);

        // start coincident with seq_done is dropped
        algo_mask = '0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        tick();
        chk("empty_seq_done", seq_done, 1);
        algo_mask = 4'b0001;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chk("coincident_start", busy, 0);
        set_all(3, 1'b1, 1'b1);
        run_seq(4'b0001, 1'b0);

        // reset in the middle of engine 2's run
        set_all(10, 1'b1, 1'b1);
        algo_mask = 4'b1111;
        start     = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (sel != 3'(ALGO_MARCH) && w < 200) begin
            tick();
            w++;
        end
        chk("reach_march", sel, ALGO_MARCH);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sel", sel, FUNC_SEL);
        chk("abort_busy", busy, 0);
        chk("abort_ran", ran_vec, 0);
        chk("abort_pass", pass_vec, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_seq(4'b1111, 1'b0);

`ifdef BIST_SEQ_RETRY_EN
        set_all(6, 1'b1, 1'b1);
        res1[ALGO_CHECKER] = 1'b0;
        run_seq(4'b0010, 1'b0);
        res2[ALGO_CHECKER] = 1'b0;
        run_seq(4'b0110, 1'b0);
`endif

        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < NA; k++) begin
                case ($urandom_range(0, 7))
                    0:       delay[k] = S + T - 1;
                    1:       delay[k] = S + T;
                    2:       delay[k] = 200;
                    default: delay[k] = int'($urandom_range(0, 12));
                endcase
                res1[k] = 1'($urandom);
                res2[k] = 1'($urandom);
            end
            run_seq(NA'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
